// File: rtl/spectrum_pkg.sv
// Shared widths and FSM encoding for the spectrum peak search block.
//   MAG_W  : bin magnitude width
//   ADDR_W : bin address width (frame of up to 1024 bins)
//   SUM_W  : frame energy accumulator width, wide enough for 1024 x 65535
package spectrum_pkg;

  localparam int MAG_W  = 16;
  localparam int ADDR_W = 10;
  localparam int SUM_W  = 26;

  // ST_HOLD: idle with a published result still waiting for the consumer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/spectrum_peak_search.sv
// spectrum_peak_search: per-frame peak and energy search over a stream of
// bin magnitudes. A frame starts at addr 0 and ends at addr BIN_MAX; the
// largest magnitude at addr >= DC_SKIP (lowest bin on ties) and the sum of
// every magnitude in the frame are published with a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   magnitude/_addr/_valid   input sample stream, no backpressure
//   peak_mag, peak_bin       frame peak
//   energy_sum               sum of all frame magnitudes
//   result_valid/ready       result handshake, result held until accepted
//   frame_err                sticky: frame aborted on address discontinuity
//   overrun                  sticky: finished frame dropped, result pending
//   err_clr                  pulse clearing both sticky flags (set wins)
//   peak_left, peak_right    (SPECTRUM_PEAK_INTERP_EN only) magnitudes of
//                            the bins either side of the peak, 0 off-frame
//
// Build option: define SPECTRUM_PEAK_INTERP_EN to add the neighbour outputs.
module spectrum_peak_search
  import spectrum_pkg::*;
#(
  parameter int DC_SKIP = 2,
  parameter int BIN_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAG_W-1:0]  magnitude,
  input  logic [ADDR_W-1:0] magnitude_addr,
  input  logic              magnitude_valid,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [SUM_W-1:0]  energy_sum,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr
`ifdef SPECTRUM_PEAK_INTERP_EN
  ,
  output logic [MAG_W-1:0]  peak_left,
  output logic [MAG_W-1:0]  peak_right
`endif
);

  localparam logic [ADDR_W-1:0] SKIP_A = ADDR_W'(DC_SKIP);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BIN_MAX);

  state_t              state;
  logic [ADDR_W-1:0]   prev_addr;
  logic [MAG_W-1:0]    run_peak;
  logic [ADDR_W-1:0]   run_bin;
  logic [SUM_W-1:0]    run_sum;

  logic                contig, in_scan, step, disc, start, take, cand;
  logic                last, transfer, publish, drop;
  logic [MAG_W-1:0]    base_peak, nxt_peak;
  logic [ADDR_W-1:0]   base_bin, nxt_bin;
  logic [SUM_W-1:0]    base_sum, nxt_sum;

  always_comb begin
    contig   = (magnitude_addr == ADDR_W'(prev_addr + ADDR_W'(1)));
    in_scan  = (state == ST_SCAN);
    step     = magnitude_valid & in_scan & contig;
    disc     = magnitude_valid & in_scan & ~contig;
    // addr 0 opens a frame from idle, and also restarts one after a
    // discontinuity in the same cycle.
    start    = magnitude_valid & (magnitude_addr == '0) & ~step;
    take     = start | step;
    // A fresh frame computes against a cleared accumulator, so the
    // start sample flows through the same update path as the rest.
    base_peak = start ? '0     : run_peak;
    base_bin  = start ? SKIP_A : run_bin;
    base_sum  = start ? '0     : run_sum;
    cand      = take & (magnitude_addr >= SKIP_A) & (magnitude > base_peak);
    nxt_peak  = cand ? magnitude      : base_peak;
    nxt_bin   = cand ? magnitude_addr : base_bin;
    nxt_sum   = base_sum + SUM_W'(magnitude);
    last      = step & (magnitude_addr == LAST_A);
    transfer  = result_valid & result_ready;
    // A consumer accept in the same cycle frees the output slot.
    publish   = last & (~result_valid | result_ready);
    drop      = last & result_valid & ~result_ready;
  end

`ifdef SPECTRUM_PEAK_INTERP_EN
  logic [MAG_W-1:0] prev_mag, run_left, run_right;
  logic             right_pend;
  logic [MAG_W-1:0] nxt_left, nxt_right;

  // Frames are contiguous, so the previous sample is always bin-1; the
  // right neighbour is picked up from the sample after a new peak.
  always_comb begin
    nxt_left  = start ? '0 : run_left;
    nxt_right = start ? '0 : run_right;
    if (cand) begin
      nxt_left  = start ? '0 : prev_mag;
      nxt_right = '0;
    end else if (right_pend && !start) begin
      nxt_right = magnitude;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_mag   <= '0;
      run_left   <= '0;
      run_right  <= '0;
      right_pend <= 1'b0;
      peak_left  <= '0;
      peak_right <= '0;
    end else begin
      if (take) begin
        prev_mag   <= magnitude;
        run_left   <= nxt_left;
        run_right  <= nxt_right;
        right_pend <= cand;
      end
      if (publish) begin
        peak_left  <= nxt_left;
        peak_right <= nxt_right;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      prev_addr    <= '0;
      run_peak     <= '0;
      run_bin      <= '0;
      run_sum      <= '0;
      peak_mag     <= '0;
      peak_bin     <= '0;
      energy_sum   <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (take) begin
        prev_addr <= magnitude_addr;
        run_peak  <= nxt_peak;
        run_bin   <= nxt_bin;
        run_sum   <= nxt_sum;
      end

      case (state)
        ST_SCAN: begin
          if (last)      state <= publish ? ST_HOLD : ST_IDLE;
          else if (disc) state <= start ? ST_SCAN : ST_IDLE;
        end
        default: begin
          // HOLD accepts a new frame exactly as IDLE does.
          if (start)                               state <= ST_SCAN;
          else if (state == ST_HOLD && transfer)   state <= ST_IDLE;
          else if (state != ST_HOLD)               state <= ST_IDLE;
        end
      endcase

      if (publish) begin
        result_valid <= 1'b1;
        peak_mag     <= nxt_peak;
        peak_bin     <= nxt_bin;
        energy_sum   <= nxt_sum;
      end else if (transfer) begin
        result_valid <= 1'b0;
      end

      frame_err <= disc | (frame_err & ~err_clr);
      overrun   <= drop | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_spectrum_peak_search.sv
// Scoreboard bench for spectrum_peak_search: frames are built in an array,
// the expected result is derived from the whole frame and queued, and a
// negedge monitor pops and compares on every result transfer.
module tb_spectrum_peak_search;
  import spectrum_pkg::*;

  localparam int DC_SKIP = 2;
  localparam int NB      = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MAG_W-1:0]  magnitude = '0;
  logic [ADDR_W-1:0] magnitude_addr = '0;
  logic              magnitude_valid = 1'b0;
  logic [MAG_W-1:0]  peak_mag;
  logic [ADDR_W-1:0] peak_bin;
  logic [SUM_W-1:0]  energy_sum;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic              frame_err, overrun;
  logic              err_clr = 1'b0;
`ifdef SPECTRUM_PEAK_INTERP_EN
  logic [MAG_W-1:0]  peak_left, peak_right;
`endif

  always #5 clk = ~clk;

  spectrum_peak_search #(.DC_SKIP(DC_SKIP), .BIN_MAX(NB-1)) dut (
    .clk(clk), .rst(rst),
    .magnitude(magnitude), .magnitude_addr(magnitude_addr),
    .magnitude_valid(magnitude_valid),
    .peak_mag(peak_mag), .peak_bin(peak_bin), .energy_sum(energy_sum),
    .result_valid(result_valid), .result_ready(result_ready),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
`ifdef SPECTRUM_PEAK_INTERP_EN
    , .peak_left(peak_left), .peak_right(peak_right)
`endif
  );

  typedef struct {
    int mag; int bin; int sum; int l; int r;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   fr [NB];
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: maximum over the searched bins, then the first bin holding it.
  function automatic exp_t model();
    exp_t e;
    int   mx = 0;
    e.sum = 0;
    e.bin = -1;
    for (int a = 0; a < NB; a++) e.sum += fr[a];
    for (int a = DC_SKIP; a < NB; a++) if (fr[a] > mx) mx = fr[a];
    for (int a = DC_SKIP; a < NB; a++) if (e.bin < 0 && fr[a] == mx) e.bin = a;
    e.mag = mx;
    e.l = (e.bin > 0)      ? fr[e.bin-1] : 0;
    e.r = (e.bin < NB - 1) ? fr[e.bin+1] : 0;
    return e;
  endfunction

  task automatic drive(input bit v, input int a, input int m);
    @(posedge clk);
    #1;
    magnitude_valid = v;
    magnitude_addr  = 10'(a);
    magnitude       = 16'(m);
    if (rand_rdy) result_ready = 1'($urandom_range(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, $urandom_range(NB-1), $urandom_range(65535));
  endtask

  task automatic send_frame(input int lo, input int hi, input int gap_pct, input bit rdy_last);
    for (int a = lo; a <= hi; a++) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) idle(1);
      drive(1, a, fr[a]);
      if (rdy_last && a == NB - 1) result_ready = 1'b1;
    end
  endtask

  task automatic fill_rand(input int maxv);
    for (int a = 0; a < NB; a++) fr[a] = $urandom_range(maxv);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((result_valid || q.size() != 0) && n < 60) begin
      idle(1);
      n++;
    end
    idle(1);
    chk({name, " result_valid idle"}, result_valid, 0);
    chk({name, " queue empty"}, q.size(), 0);
  endtask

  task automatic pulse_clr();
    idle(1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && result_valid && result_ready) begin
      if (q.size() == 0) begin
        chk("unexpected result", 1, 0);
      end else begin
        e = q.pop_front();
        chk("peak_mag", peak_mag, e.mag);
        chk("peak_bin", peak_bin, e.bin);
        chk("energy_sum", energy_sum, e.sum);
`ifdef SPECTRUM_PEAK_INTERP_EN
        chk("peak_left", peak_left, e.l);
        chk("peak_right", peak_right, e.r);
`endif
      end
    end
  end

  initial begin
    exp_t ea;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset result_valid", result_valid, 0);
    chk("reset peak_mag", peak_mag, 0);
    chk("reset peak_bin", peak_bin, 0);
    chk("reset energy_sum", energy_sum, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);

    // Non-zero addresses in idle must not start a frame.
    drive(1, 5, 999);
    drive(1, 1023, 999);
    idle(3);
    chk("idle ignore", result_valid, 0);

    // Ramp frame, one-cycle publication latency and single-cycle pulse.
    for (int a = 0; a < NB; a++) fr[a] = a;
    q.push_back(model());
    send_frame(0, NB-1, 0, 0);
    idle(1);
    chk("ramp latency", result_valid, 1);
    idle(1);
    chk("ramp pulse", result_valid, 0);
    drain("ramp");

    // Flat frame with equal peaks, lowest searched bin wins.
    for (int a = 0; a < NB; a++) fr[a] = 100;
    fr[0] = 500; fr[300] = 500; fr[700] = 500;
    q.push_back(model());
    send_frame(0, NB-1, 0, 0);
    drain("flat");

    // Known neighbours around a peak, gaps in valid.
    fill_rand(250);
    fr[39] = 300; fr[40] = 900; fr[41] = 450;
    q.push_back(model());
    send_frame(0, NB-1, 20, 0);
    drain("interp");

    // Random frames (narrow ranges force ties, zero frame), random ready.
    rand_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fill_rand(k == 0 ? 65535 : k == 1 ? 15 : k == 2 ? 0 : 3);
      q.push_back(model());
      send_frame(0, NB-1, 10, 0);
      idle(5);
    end
    rand_rdy = 1'b0;
    result_ready = 1'b1;
    drain("random");

    // Address jump: err_clr on the same cycle must lose to the set.
    fill_rand(1000);
    send_frame(0, 10, 0, 0);
    drive(1, 12, fr[12]);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    send_frame(13, NB-1, 0, 0);
    idle(3);
    chk("jump frame_err", frame_err, 1);
    chk("jump no result", result_valid, 0);
    chk("jump queue", q.size(), 0);
    pulse_clr();
    chk("jump clr", frame_err, 0);
    fill_rand(65535);
    q.push_back(model());
    send_frame(0, NB-1, 0, 0);
    drain("after jump");

    // Addr 0 mid-frame restarts immediately.
    fill_rand(65535);
    send_frame(0, 50, 0, 0);
    fill_rand(65535);
    q.push_back(model());
    send_frame(0, NB-1, 5, 0);
    drain("restart");
    chk("restart frame_err", frame_err, 1);
    pulse_clr();

    // Reset in the middle of a frame.
    fill_rand(65535);
    send_frame(0, 500, 0, 0);
    idle(1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst result_valid", result_valid, 0);
    chk("midrst peak_mag", peak_mag, 0);
    chk("midrst energy_sum", energy_sum, 0);
    fill_rand(65535);
    q.push_back(model());
    send_frame(0, NB-1, 0, 0);
    drain("post reset");

    // Overrun: held result, dropped frame, then accept + publish together.
    result_ready = 1'b0;
    fill_rand(65535);
    ea = model();
    q.push_back(ea);
    send_frame(0, NB-1, 0, 0);
    idle(1);
    chk("hold valid", result_valid, 1);
    fill_rand(65535);
    send_frame(0, NB-1, 0, 0);
    idle(2);
    chk("overrun set", overrun, 1);
    chk("hold valid2", result_valid, 1);
    chk("hold peak_mag", peak_mag, ea.mag);
    chk("hold peak_bin", peak_bin, ea.bin);
    chk("hold energy_sum", energy_sum, ea.sum);
    pulse_clr();
    chk("overrun clr", overrun, 0);
    fill_rand(65535);
    q.push_back(model());
    send_frame(0, NB-1, 0, 1);
    idle(2);
    chk("same-cycle no overrun", overrun, 0);
    drain("same-cycle");

    chk("final queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
